// File: rtl/avalon_mem_bridge_pkg.sv
// Shared types and constants for avalon_mem_bridge: FSM states, LFSR constants, wait-counter width.
package avalon_mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0].
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // 4 bits cover the programmed wait (0-15), 2 more absorb the random extra (0-3).
  localparam int WAIT_W  = 4;
  localparam int EXTRA_W = 2;
  localparam int CNT_W   = WAIT_W + EXTRA_W;

endpackage

// File: rtl/avalon_mem_bridge_if.sv
// Avalon-MM port bundle between the CPU bus master and the avalon_mem_bridge slave.
interface avalon_mem_bridge_if;

  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata
  );

endinterface

// File: rtl/avalon_mem_bridge_lfsr16.sv
// 16-bit Fibonacci LFSR used to add pseudo-random stall cycles to bridge transfers.
module lfsr16
  import avalon_mem_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= LFSR_SEED;
    end else if (en) begin
      value <= {value[14:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/avalon_mem_bridge.sv
// Avalon-MM slave to single-port synchronous SRAM bridge with programmable wait states.
// Define BRIDGE_STALL_RANDOM_EN to add 0-3 pseudo-random extra wait cycles per transfer.
module avalon_mem_bridge
  import avalon_mem_bridge_pkg::*;
#(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 3,
  parameter int MEM_AW     = 11
) (
  input  logic                clk,
  input  logic                reset,
  avalon_mem_bridge_if.slave  bus,
  output logic                protocol_error,
  output logic                mem_en,
  output logic                mem_we,
  output logic [3:0]          mem_be,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  localparam logic [CNT_W-1:0] READ_N  = CNT_W'(READ_WAIT);
  localparam logic [CNT_W-1:0] WRITE_N = CNT_W'(WRITE_WAIT);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_cnt;
  logic             is_write;
  logic             any_req;
  logic             both_req;
  logic             req_held;
  logic [31:0]      hold_q;
  logic             unused_bits;

  assign any_req  = bus.read | bus.write;
  assign both_req = bus.read & bus.write;
  // Abort test follows the request type that was accepted, not whichever line is high now.
  assign req_held = is_write ? bus.write : bus.read;

`ifdef BRIDGE_STALL_RANDOM_EN
  logic [15:0] lfsr_q;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (reset),
    .en    (1'b1),
    .value (lfsr_q)
  );

  assign load_cnt    = (bus.write ? WRITE_N : READ_N) + CNT_W'(lfsr_q[1:0]);
  assign unused_bits = ^{bus.address[31:MEM_AW+2], lfsr_q[15:2]};
`else
  assign load_cnt    = bus.write ? WRITE_N : READ_N;
  assign unused_bits = ^bus.address[31:MEM_AW+2];
`endif

  // The master holds address/data stable while stalled, so the RAM side is a straight feed-through.
  assign mem_addr  = bus.address[MEM_AW+1:2];
  assign mem_be    = bus.byteenable;
  assign mem_wdata = bus.writedata;

  // A simultaneous read+write in IDLE is dropped, so it must not stall the master.
  assign bus.waitrequest = reset & any_req & (state != ST_RESP)
                         & ~((state == ST_IDLE) & both_req);
  assign bus.readdata    = (state == ST_RESP && !is_write) ? mem_rdata : hold_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      is_write       <= 1'b0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      hold_q         <= '0;
      protocol_error <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (both_req) begin
            protocol_error <= 1'b1;
          end else if (any_req) begin
            is_write <= bus.write;
            if (bus.address[1:0] != 2'b00) begin
              protocol_error <= 1'b1;
            end
            if (load_cnt == '0) begin
              state  <= ST_ACCESS;
              mem_en <= 1'b1;
              mem_we <= bus.write;
            end else begin
              cnt   <= load_cnt;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!req_held) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_W'(1)) begin
            state  <= ST_ACCESS;
            cnt    <= '0;
            mem_en <= 1'b1;
            mem_we <= is_write;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_ACCESS: begin
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (!is_write) begin
            hold_q <= mem_rdata;
          end
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_mem_bridge.sv
// Self-checking bench for avalon_mem_bridge: default-latency instance plus a zero-wait instance sharing one RAM.
module tb_avalon_mem_bridge;

  localparam int AW = 11;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  avalon_mem_bridge_if bus_m ();
  avalon_mem_bridge_if bus_f ();

  logic            m_perr, m_en, m_we, f_perr, f_en, f_we;
  logic [3:0]      m_be, f_be;
  logic [AW-1:0]   m_addr, f_addr;
  logic [31:0]     m_wdata, f_wdata;
  logic [31:0]     mem_rdata = '0;
  logic [31:0]     ram [2048] = '{default: '0};

  avalon_mem_bridge u_dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus_m.slave),
    .protocol_error (m_perr),
    .mem_en         (m_en),
    .mem_we         (m_we),
    .mem_be         (m_be),
    .mem_addr       (m_addr),
    .mem_wdata      (m_wdata),
    .mem_rdata      (mem_rdata)
  );

  avalon_mem_bridge #(.READ_WAIT(0), .WRITE_WAIT(0)) u_fast (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus_f.slave),
    .protocol_error (f_perr),
    .mem_en         (f_en),
    .mem_we         (f_we),
    .mem_be         (f_be),
    .mem_addr       (f_addr),
    .mem_wdata      (f_wdata),
    .mem_rdata      (mem_rdata)
  );

  // Only one bridge is exercised at a time; sel picks whose outputs are observed.
  logic sel = 1'b0;
  logic act_wait, act_en, act_we, act_perr;
  logic [3:0]    act_be;
  logic [AW-1:0] act_addr;
  logic [31:0]   act_wdata, act_rd;

  assign act_wait  = sel ? bus_f.waitrequest : bus_m.waitrequest;
  assign act_rd    = sel ? bus_f.readdata    : bus_m.readdata;
  assign act_en    = sel ? f_en    : m_en;
  assign act_we    = sel ? f_we    : m_we;
  assign act_perr  = sel ? f_perr  : m_perr;
  assign act_be    = sel ? f_be    : m_be;
  assign act_addr  = sel ? f_addr  : m_addr;
  assign act_wdata = sel ? f_wdata : m_wdata;

  // Synchronous single-port RAM: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (act_en) begin
      if (act_we) begin
        for (int i = 0; i < 4; i++) begin
          if (act_be[i]) ram[act_addr][8*i +: 8] <= act_wdata[8*i +: 8];
        end
      end else begin
        mem_rdata <= ram[act_addr];
      end
    end
  end

  // Transaction-level model: memory image, per-bridge hold value and error flag.
  logic [31:0] model_mem [2048] = '{default: '0};
  logic [31:0] exp_hold [2];
  logic        exp_perr [2];
  logic        chk_en = 1'b0;
  logic        exp_wait, exp_en, exp_we;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wdata, exp_rd;

  int n_checks = 0;
  int n_pass   = 0;
  int obs_wait_hi, obs_en;
  logic [31:0] obs_addr, obs_rd;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s at %0t: got %h, want %h", name, $time, got, want);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("waitrequest", 32'(act_wait), 32'(exp_wait));
      check("mem_en", 32'(act_en), 32'(exp_en));
      check("readdata", act_rd, exp_rd);
      check("protocol_error", 32'(act_perr), 32'(exp_perr[sel]));
      if (exp_en) begin
        check("mem_we", 32'(act_we), 32'(exp_we));
        check("mem_addr", 32'(act_addr), exp_addr);
        if (exp_we) begin
          check("mem_wdata", act_wdata, exp_wdata);
          check("mem_be", 32'(act_be), 32'(exp_be));
        end
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    bus_m.read = rd & ~sel;  bus_m.write = wr & ~sel;
    bus_f.read = rd &  sel;  bus_f.write = wr &  sel;
    bus_m.address = a;  bus_m.byteenable = be;  bus_m.writedata = d;
    bus_f.address = a;  bus_f.byteenable = be;  bus_f.writedata = d;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int c = 0; c < k; c++) begin
      drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      exp_wait = 1'b0;
      exp_en   = 1'b0;
      exp_rd   = exp_hold[sel];
      next_cycle();
    end
  endtask

  // One accepted transfer held for its full N+3 cycles: IDLE, N x WAIT, ACCESS, RESP.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d, input int n);
    logic [31:0] word;
    word = model_mem[a[12:2]];
    obs_wait_hi = 0; obs_en = 0; obs_addr = '0; obs_rd = '0;
    for (int c = 1; c <= n + 3; c++) begin
      drive(~wr, wr, a, be, d);
      exp_wait  = (c != n + 3);
      exp_en    = (c == n + 2);
      exp_we    = wr;
      exp_addr  = 32'(a[12:2]);
      exp_wdata = d;
      exp_be    = be;
      exp_rd    = (!wr && c == n + 3) ? word : exp_hold[sel];
      if (c == 2 && a[1:0] != 2'b00) exp_perr[sel] = 1'b1;
      @(negedge clk);
      if (act_wait) obs_wait_hi++;
      if (act_en) begin
        obs_en++;
        obs_addr = 32'(act_addr);
      end
      if (c == n + 3) obs_rd = act_rd;
      @(posedge clk);
      #1;
    end
    if (wr) model_mem[a[12:2]] = merge(word, d, be);
    else    exp_hold[sel] = word;
  endtask

  initial begin
    exp_hold[0] = '0; exp_hold[1] = '0;
    exp_perr[0] = 1'b0; exp_perr[1] = 1'b0;
    exp_we = 1'b0; exp_be = '0; exp_addr = '0; exp_wdata = '0;

    // Reset with a read held: waitrequest must stay low, outputs at reset values.
    drive(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    exp_wait = 1'b0; exp_en = 1'b0; exp_rd = '0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_mem_we", 32'(act_we), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);

    xfer(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 3);
    check("wr_wait_cycles", 32'(obs_wait_hi), 32'd5);
    check("wr_en_pulses", 32'(obs_en), 32'd1);
    check("wr_mem_addr", obs_addr, 32'd4);
    idle(1);

    xfer(1'b0, 32'h10, 4'hF, 32'h0, 2);
    check("rd_literal", obs_rd, 32'hDEADBEEF);
    check("rd_wait_cycles", 32'(obs_wait_hi), 32'd4);
    idle(3);

    xfer(1'b1, 32'h10, 4'b0001, 32'h000000AB, 3);
    idle(1);
    xfer(1'b0, 32'h10, 4'hF, 32'h0, 2);
    check("merge_literal", obs_rd, 32'hDEADBEAB);
    idle(1);

    // Write abandoned after two WAIT cycles, dropped exactly when the count reaches 1.
    for (int c = 1; c <= 3; c++) begin
      drive(1'b0, 1'b1, 32'h20, 4'hF, 32'h5555AAAA);
      exp_wait = 1'b1; exp_en = 1'b0; exp_rd = exp_hold[sel];
      next_cycle();
    end
    idle(3);
    xfer(1'b0, 32'h20, 4'hF, 32'h0, 2);
    check("abort_no_write", obs_rd, 32'h0);
    idle(1);

    // Reset lands in the WAIT phase of a write to the word holding DEADBEAB.
    for (int c = 1; c <= 2; c++) begin
      drive(1'b0, 1'b1, 32'h10, 4'hF, 32'h12345678);
      exp_wait = 1'b1; exp_en = 1'b0; exp_rd = exp_hold[sel];
      next_cycle();
    end
    reset = 1'b0;
    exp_hold[0] = '0; exp_hold[1] = '0;
    exp_perr[0] = 1'b0; exp_perr[1] = 1'b0;
    exp_wait = 1'b0; exp_en = 1'b0; exp_rd = '0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    idle(4);
    xfer(1'b0, 32'h10, 4'hF, 32'h0, 2);
    check("reset_keeps_ram", obs_rd, 32'hDEADBEAB);
    idle(1);

    // Zero-wait bridge: back-to-back writes then back-to-back reads.
    sel = 1'b1;
    xfer(1'b1, 32'h0, 4'hF, 32'h11111111, 0);
    check("fast_wait_cycles", 32'(obs_wait_hi), 32'd2);
    xfer(1'b1, 32'h4, 4'hF, 32'h22222222, 0);
    xfer(1'b0, 32'h0, 4'hF, 32'h0, 0);
    check("b2b_rd0", obs_rd, 32'h11111111);
    xfer(1'b0, 32'h4, 4'hF, 32'h0, 0);
    check("b2b_rd1", obs_rd, 32'h22222222);

    // read and write together in IDLE: dropped, no stall, sticky error.
    drive(1'b1, 1'b1, 32'h8, 4'hF, 32'h0);
    exp_wait = 1'b0; exp_en = 1'b0; exp_rd = exp_hold[sel];
    next_cycle();
    exp_perr[sel] = 1'b1;
    idle(2);
    check("rw_error_literal", 32'(f_perr), 32'd1);
    xfer(1'b0, 32'h4, 4'hF, 32'h0, 0);
    idle(1);

    // Misaligned read on the default bridge: flagged, served from the truncated word.
    sel = 1'b0;
    xfer(1'b0, 32'h13, 4'hF, 32'h0, 2);
    check("misaligned_addr", obs_addr, 32'd4);
    check("misaligned_data", obs_rd, 32'hDEADBEAB);
    idle(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
